// File: rtl/relobi_req_arbiter.sv
// relobi_req_arbiter: round-robin arbiter sharing one reliable-OBI subordinate port between NumMgr managers
// Ports: clk_i/rst_i clock and synchronous active-high reset;
//   mgr_req_i/mgr_gnt_o/mgr_a_i   manager request, grant and A channel (ECC fields passed untouched);
//   mgr_rvalid_o/mgr_r_o          response valid routed to the issuing manager, R channel broadcast;
//   sbr_req_o/sbr_gnt_i/sbr_a_o   subordinate request, grant and selected A channel;
//   sbr_rvalid_i/sbr_r_i          subordinate response;
//   busy_o                        at least one transaction outstanding;
//   spurious_o                    sticky, rvalid seen with nothing outstanding;
//   timeout_o                     sticky response timeout, present only with RELOBI_ARB_TIMEOUT_EN defined.
package obi_pkg;
    typedef struct packed {
        int unsigned addr_width;
        int unsigned data_width;
    } obi_cfg_t;
    localparam obi_cfg_t ObiDefaultConfig = '{addr_width: 32, data_width: 32};
endpackage

module relobi_req_arbiter #(
    parameter obi_pkg::obi_cfg_t ObiCfg        = obi_pkg::ObiDefaultConfig,
    parameter type               obi_a_chan_t  = logic,
    parameter type               obi_r_chan_t  = logic,
    parameter int unsigned       NumMgr        = 4,
    parameter int unsigned       MaxTrans      = 4,
    parameter int unsigned       TimeoutCycles = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumMgr-1:0] mgr_req_i,
    output logic [NumMgr-1:0] mgr_gnt_o,
    input  obi_a_chan_t       mgr_a_i [NumMgr],
    output logic [NumMgr-1:0] mgr_rvalid_o,
    output obi_r_chan_t       mgr_r_o,
    output logic              sbr_req_o,
    input  logic              sbr_gnt_i,
    output obi_a_chan_t       sbr_a_o,
    input  logic              sbr_rvalid_i,
    input  obi_r_chan_t       sbr_r_i,
    output logic              busy_o,
    output logic              spurious_o
`ifdef RELOBI_ARB_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);
    localparam int unsigned MW = NumMgr > 1 ? $clog2(NumMgr) : 1;
    localparam int unsigned PW = MaxTrans > 1 ? $clog2(MaxTrans) : 1;
    localparam int unsigned CW = $clog2(MaxTrans + 1);
    typedef logic [MW-1:0] idx_t;
    typedef enum logic {IDLE, HOLD} state_e;
    state_e        state_q, state_d;
    idx_t          rr_q, rr_d, sel_q, sel_d, win, cur;
    idx_t          fifo_q [MaxTrans];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          full, gnt, pop, spurious_q;

    function automatic idx_t wrap_idx(input int k);
        return idx_t'(k >= int'(NumMgr) ? k - int'(NumMgr) : k);
    endfunction

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return p == PW'(MaxTrans - 1) ? '0 : p + PW'(1);
    endfunction

    // Scanning from the farthest offset down leaves the closest request at or after rr_q.
    always_comb begin
        win = rr_q;
        for (int i = int'(NumMgr) - 1; i >= 0; i--)
            win = mgr_req_i[wrap_idx(int'(rr_q) + i)] ? wrap_idx(int'(rr_q) + i) : win;
    end

    // Full uses the registered count, so a same-cycle pop does not unblock arbitration.
    always_comb begin
        full         = cnt_q == CW'(MaxTrans);
        cur          = state_q == HOLD ? sel_q : win;
        sbr_req_o    = !full && (state_q == HOLD ? mgr_req_i[sel_q] : |mgr_req_i);
        sbr_a_o      = (state_q == HOLD || sbr_req_o) ? mgr_a_i[cur] : '0;
        gnt          = sbr_req_o && sbr_gnt_i;
        mgr_gnt_o    = '0;
        mgr_gnt_o[cur] = gnt;
        pop          = sbr_rvalid_i && cnt_q != '0;
        mgr_rvalid_o = '0;
        mgr_rvalid_o[fifo_q[rd_q]] = pop;
        rr_d         = gnt ? wrap_idx(int'(cur) + 1) : rr_q;
        state_d      = state_q == IDLE ? (sbr_req_o && !sbr_gnt_i ? HOLD : IDLE) : (gnt ? IDLE : HOLD);
        sel_d        = state_q == IDLE && sbr_req_o && !sbr_gnt_i ? win : sel_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_q + CW'(gnt) - CW'(pop);
            wr_q       <= gnt ? nxt_ptr(wr_q) : wr_q;
            rd_q       <= pop ? nxt_ptr(rd_q) : rd_q;
            spurious_q <= spurious_q | (sbr_rvalid_i && cnt_q == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt) fifo_q[wr_q] <= cur;
    end

    assign mgr_r_o    = sbr_r_i;
    assign busy_o     = cnt_q != '0;
    assign spurious_o = spurious_q;

`ifdef RELOBI_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q;

    // Counts cycles spent waiting on the oldest response; saturates at the threshold.
    always_comb begin
        tcnt_d = (cnt_q == '0 || sbr_rvalid_i) ? '0 :
                 (tcnt_q == TW'(TimeoutCycles) ? tcnt_q : tcnt_q + TW'(1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_q | (tcnt_d == TW'(TimeoutCycles));
        end
    end

    assign timeout_o = timeout_q;
`endif
endmodule
